// File: rtl/board_input_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apple1_board_pkg
// Description : Shared board-level definitions: system reset sequencer state
//               encoding and keyboard source select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package apple1_board_pkg;

  // System reset sequencer states
  typedef enum logic [1:0] {
    S_POR     = 2'd0,
    S_RUN     = 2'd1,
    S_HELD    = 2'd2,
    S_STRETCH = 2'd3
  } state_t;

  // Keyboard source codes, shared with the core's keyboard mux
  localparam logic [1:0] KEY_SEL_UART = 2'b00;
  localparam logic [1:0] KEY_SEL_PS2  = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : board_input_ctrl_if
// Description : Board pins into the conditioning stage and the conditioned
//               controls out to the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface board_input_ctrl_if;
  logic       button_in;
  logic       switch_in;
  logic       sys_rst_n;
  logic       vga_cls;
  logic [1:0] key_select;

  // Board side / stimulus drives the raw inputs
  modport master (
    output button_in, switch_in,
    input  sys_rst_n, vga_cls, key_select
  );

  // Conditioning stage consumes raw inputs and drives core controls
  modport slave (
    input  button_in, switch_in,
    output sys_rst_n, vga_cls, key_select
  );
endinterface
`default_nettype wire

// File: rtl/board_input_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : Two-flop synchroniser followed by a counter debouncer. A new
//               level is accepted after DEBOUNCE_CYCLES consecutive samples.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int                 c_cnt_w    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic [c_cnt_w-1:0] r_cnt;

  // Bring the asynchronous pin into the clk25 domain
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has held for the full count;
  // any return to the old level restarts the count
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dout = r_stable;

endmodule
`default_nettype wire

// File: rtl/board_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : board_input_ctrl
// Description : Board input conditioning ahead of the apple1 core: debounced
//               reset button and keyboard-source switch, power-on reset and
//               stretched system reset sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module board_input_ctrl
  import apple1_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int POR_CYCLES      = 1024,
  parameter int STRETCH_CYCLES  = 64
) (
  input  logic               clk25,
  input  logic               rst_n,
  board_input_ctrl_if.slave  bus
);

  localparam int                  c_tmax     = max_int(POR_CYCLES, STRETCH_CYCLES);
  localparam int                  c_tcnt_w   = (c_tmax > 1) ? $clog2(c_tmax) : 1;
  localparam logic [c_tcnt_w-1:0] c_por_last = c_tcnt_w'(POR_CYCLES - 1);
  localparam logic [c_tcnt_w-1:0] c_str_last = c_tcnt_w'(STRETCH_CYCLES - 1);

  logic                w_btn_stable;
  logic                w_sw_stable;
  state_t              r_state;
  state_t              w_next_state;
  logic [c_tcnt_w-1:0] r_tcnt;
  logic [c_tcnt_w-1:0] w_tcnt_next;
  logic                r_sys_rst_n;
  logic                r_vga_cls;
  logic [1:0]          r_key_select;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
    .clk25 (clk25),
    .rst_n (rst_n),
    .din   (bus.button_in),
    .dout  (w_btn_stable)
  );

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_debounce (
    .clk25 (clk25),
    .rst_n (rst_n),
    .din   (bus.switch_in),
    .dout  (w_sw_stable)
  );

  // Sequencer state and shared POR/stretch timer
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_POR;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_tcnt  <= w_tcnt_next;
    end
  end

  // Next-state and timer logic; a re-press during stretch wins over timeout
  always_comb begin
    w_next_state = r_state;
    w_tcnt_next  = r_tcnt;
    case (r_state)
      S_POR: begin
        if (r_tcnt == c_por_last) begin
          w_tcnt_next  = '0;
          w_next_state = w_btn_stable ? S_HELD : S_RUN;
        end else begin
          w_tcnt_next = r_tcnt + 1'b1;
        end
      end
      S_RUN: begin
        if (w_btn_stable) w_next_state = S_HELD;
      end
      S_HELD: begin
        if (!w_btn_stable) begin
          w_tcnt_next  = '0;
          w_next_state = S_STRETCH;
        end
      end
      S_STRETCH: begin
        if (w_btn_stable) begin
          w_tcnt_next  = '0;
          w_next_state = S_HELD;
        end else if (r_tcnt == c_str_last) begin
          w_tcnt_next  = '0;
          w_next_state = S_RUN;
        end else begin
          w_tcnt_next = r_tcnt + 1'b1;
        end
      end
      default: begin
        w_tcnt_next  = '0;
        w_next_state = S_POR;
      end
    endcase
  end

  // Registered core controls; the switch never disturbs the core reset
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_sys_rst_n  <= 1'b0;
      r_vga_cls    <= 1'b1;
      r_key_select <= KEY_SEL_UART;
    end else begin
      r_sys_rst_n  <= (w_next_state == S_RUN);
      r_vga_cls    <= (w_next_state != S_RUN);
      r_key_select <= w_sw_stable ? KEY_SEL_PS2 : KEY_SEL_UART;
    end
  end

  assign bus.sys_rst_n  = r_sys_rst_n;
  assign bus.vga_cls    = r_vga_cls;
  assign bus.key_select = r_key_select;

endmodule
`default_nettype wire

// File: tb/tb_board_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_input_ctrl
// Description : Self-checking bench for board_input_ctrl with
//               DEBOUNCE_CYCLES=4, POR_CYCLES=8, STRETCH_CYCLES=6.
//               Expected {sys_rst_n, vga_cls, key_select} per edge are queued
//               when stimulus is applied and compared one per clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_input_ctrl;

  logic clk25 = 1'b0;
  logic rst_n = 1'b1;

  board_input_ctrl_if bus();

  board_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .POR_CYCLES      (8),
    .STRETCH_CYCLES  (6)
  ) dut (
    .clk25 (clk25),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk25 = ~clk25;

  logic [3:0] sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Step to just after the next rising edge
  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  // Expected {sys_rst_n, vga_cls, key_select}
  function automatic logic [3:0] ex(input logic r, input logic [1:0] ks);
    return {r, ~r, ks};
  endfunction

  task automatic test_reset();
    logic [3:0] e, o;
    for (int i = 1; i <= 3; i++) sb.push_back(ex(1'b0, 2'b00));
    for (int i = 1; i <= 3; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL reset edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_power_on();
    logic [3:0] e, o;
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) sb.push_back(ex(i >= 8, 2'b00));
    for (int i = 1; i <= 10; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL power_on edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic [3:0] e, o;
    bus.button_in = 1'b1;
    for (int i = 1; i <= 20; i++) sb.push_back(ex(1'b1, 2'b00));
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3) bus.button_in = 1'b0;
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL glitch edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_press_release();
    logic [3:0] e, o;
    bus.button_in = 1'b1;
    for (int i = 1; i <= 12; i++) sb.push_back(ex(i <= 6, 2'b00));
    for (int i = 1; i <= 12; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL press edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
    bus.button_in = 1'b0;
    for (int i = 1; i <= 16; i++) sb.push_back(ex(i >= 13, 2'b00));
    for (int i = 1; i <= 16; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL release edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_held_por();
    logic [3:0] e, o;
    rst_n         = 1'b0;
    bus.button_in = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) sb.push_back(ex(1'b0, 2'b00));
    for (int i = 1; i <= 12; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL held_por edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
    bus.button_in = 1'b0;
    for (int i = 1; i <= 16; i++) sb.push_back(ex(i >= 13, 2'b00));
    for (int i = 1; i <= 16; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL held_release edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_switch();
    logic [3:0] e, o;
    // Clean change to PS/2: no effect on core reset
    bus.switch_in = 1'b1;
    for (int i = 1; i <= 10; i++) sb.push_back(ex(1'b1, (i >= 7) ? 2'b10 : 2'b00));
    for (int i = 1; i <= 10; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL switch edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
    // Two-cycle bounce back to UART is ignored
    bus.switch_in = 1'b0;
    for (int i = 1; i <= 12; i++) sb.push_back(ex(1'b1, 2'b10));
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 2) bus.switch_in = 1'b1;
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL switch_bounce edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
    // Press and switch change together are honoured on the same edge
    bus.button_in = 1'b1;
    bus.switch_in = 1'b0;
    for (int i = 1; i <= 10; i++) sb.push_back(ex(i <= 6, (i <= 6) ? 2'b10 : 2'b00));
    for (int i = 1; i <= 10; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL simultaneous edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
    bus.button_in = 1'b0;
    for (int i = 1; i <= 14; i++) sb.push_back(ex(i >= 13, 2'b00));
    for (int i = 1; i <= 14; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL simul_release edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stretch();
    logic [3:0] e, o;
    bus.button_in = 1'b1;
    bus.switch_in = 1'b1;
    for (int i = 1; i <= 12; i++) sb.push_back(ex(i <= 6, (i >= 7) ? 2'b10 : 2'b00));
    for (int i = 1; i <= 12; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL mid_press edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
    // Stretch begins at edge 7; edge 10 leaves the timer at 3
    bus.button_in = 1'b0;
    for (int i = 1; i <= 10; i++) sb.push_back(ex(1'b0, 2'b10));
    for (int i = 1; i <= 10; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL mid_stretch edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
    // Asynchronous reset between edges
    #4;
    rst_n = 1'b0;
    sb.push_back(ex(1'b0, 2'b00));
    #1;
    e = sb.pop_front();
    o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
    n_checks++;
    if (o !== e) $display("FAIL async_reset: got %b expected %b", o, e);
    else n_pass++;
    tick();
    tick();
    // Full POR follows; held switch re-debounces from reset
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) sb.push_back(ex(i >= 8, (i >= 7) ? 2'b10 : 2'b00));
    for (int i = 1; i <= 10; i++) begin
      tick();
      e = sb.pop_front();
      o = {bus.sys_rst_n, bus.vga_cls, bus.key_select};
      n_checks++;
      if (o !== e) $display("FAIL post_reset_por edge %0d: got %b expected %b", i, o, e);
      else n_pass++;
    end
  endtask

  initial begin
    bus.button_in = 1'b0;
    bus.switch_in = 1'b0;
    #5;
    rst_n = 1'b0;
    test_reset();
    test_power_on();
    test_glitch();
    test_press_release();
    test_held_por();
    test_switch();
    test_reset_mid_stretch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
